// File: rtl/ofifo_col_pkg.sv
// ofifo_col_pkg: shared defaults and pointer-width helper for the column output FIFO
package ofifo_col_pkg;
  localparam int def_col     = 8;
  localparam int def_psum_bw = 16;
  localparam int def_depth   = 64;
  function automatic int ptr_width(input int d);
    return $clog2(d) + 1;
  endfunction
  localparam int ptr_w = ptr_width(def_depth);
endpackage

// File: rtl/ofifo_col_if.sv
// ofifo_col_if: column-write / row-read bus; master = SFP + writeback side, slave = ofifo_col
//   in_data  packed column data, column k in [(k+1)*psum_bw-1 : k*psum_bw]
//   wr       per-column write enables
//   rd       row read request
//   out_data registered row read data, same packing as in_data
//   valid    out_data was updated with a new row this cycle
//   ready    every column holds data
//   full     at least one column is full
//   ovf/unf  sticky overflow / underflow flags
interface ofifo_col_if
  import ofifo_col_pkg::*;
#(
  parameter int col     = def_col,
  parameter int psum_bw = def_psum_bw
);
  logic [psum_bw*col-1:0] in_data;
  logic [psum_bw*col-1:0] out_data;
  logic [col-1:0]         wr;
  logic                   rd;
  logic                   valid;
  logic                   ready;
  logic                   full;
  logic                   ovf;
  logic                   unf;
  modport master (output in_data, wr, rd, input out_data, valid, ready, full, ovf, unf);
  modport slave  (input in_data, wr, rd, output out_data, valid, ready, full, ovf, unf);
endinterface

// File: rtl/fifo_col.sv
// fifo_col: single-column synchronous FIFO with a combinational head read
//   clk, reset  clock and asynchronous active-high reset
//   wr_i, din_i write request and data
//   pop_i       advance the read pointer (caller guarantees non-empty)
//   dout_o      head entry
//   empty_o, full_o occupancy status from the pointers
//   ovf_o       pulse: this cycle's write is dropped
module fifo_col
  import ofifo_col_pkg::*;
#(
  parameter int psum_bw = def_psum_bw,
  parameter int depth   = def_depth
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_i,
  input  logic [psum_bw-1:0] din_i,
  input  logic               pop_i,
  output logic [psum_bw-1:0] dout_o,
  output logic               empty_o,
  output logic               full_o,
  output logic               ovf_o
);
  localparam int aw = $clog2(depth);
  localparam int pw = ptr_width(depth);
  logic [psum_bw-1:0] mem_q [depth];
  logic [pw-1:0] wptr_d, wptr_q, rptr_d, rptr_q;
  logic push;
  assign empty_o = wptr_q == rptr_q;
  assign full_o  = (wptr_q[aw] != rptr_q[aw]) && (wptr_q[aw-1:0] == rptr_q[aw-1:0]);
  // A write into a full column is still taken when the head leaves in the same cycle:
  // it lands in the slot being vacated, which is read out before the edge overwrites it.
  assign push    = wr_i && (!full_o || pop_i);
  assign ovf_o   = wr_i && full_o && !pop_i;
  assign dout_o  = mem_q[rptr_q[aw-1:0]];
  always_comb begin
    wptr_d = push ? wptr_q + pw'(1) : wptr_q;
    rptr_d = pop_i ? rptr_q + pw'(1) : rptr_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[aw-1:0]] <= din_i;
  end
endmodule

// File: rtl/ofifo_col.sv
// ofifo_col: per-column output FIFOs written independently, read back as whole rows
//   clk, reset  clock and asynchronous active-high reset
//   bus         ofifo_col_if slave: column writes in, registered row reads and status out
module ofifo_col
  import ofifo_col_pkg::*;
#(
  parameter int col     = def_col,
  parameter int psum_bw = def_psum_bw,
  parameter int depth   = def_depth
) (
  input logic        clk,
  input logic        reset,
  ofifo_col_if.slave bus
);
  logic [col-1:0] empty, full, ovf;
  logic [psum_bw*col-1:0] row, out_d, out_q;
  logic ready, pop;
  logic valid_d, valid_q, ovf_d, ovf_q, unf_d, unf_q;
  for (genvar k = 0; k < col; k++) begin : g_col
    fifo_col #(.psum_bw(psum_bw), .depth(depth)) u_col (
      .clk    (clk),
      .reset  (reset),
      .wr_i   (bus.wr[k]),
      .din_i  (bus.in_data[k*psum_bw +: psum_bw]),
      .pop_i  (pop),
      .dout_o (row[k*psum_bw +: psum_bw]),
      .empty_o(empty[k]),
      .full_o (full[k]),
      .ovf_o  (ovf[k])
    );
  end
  assign ready = ~|empty;
  assign pop   = bus.rd && ready;
  always_comb begin
    out_d   = pop ? row : out_q;
    valid_d = pop;
    ovf_d   = ovf_q || (|ovf);
    unf_d   = unf_q || (bus.rd && !ready);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q   <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      out_q   <= out_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end
  assign bus.out_data = out_q;
  assign bus.valid    = valid_q;
  assign bus.ready    = ready;
  assign bus.full     = |full;
  assign bus.ovf      = ovf_q;
  assign bus.unf      = unf_q;
endmodule

// File: tb/tb_ofifo_col.sv
// tb_ofifo_col: scoreboard bench for ofifo_col with per-column queue model
module tb_ofifo_col;
  logic clk = 1'b0;
  logic reset = 1'b0;
  ofifo_col_if bus ();
  ofifo_col dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  logic [15:0] mq [8][$];
  logic [127:0] sb [$];
  logic [127:0] last_out = '0;
  bit e_ovf = 0;
  bit e_unf = 0;
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic check_outputs(input bit ev);
    bit mr, mf;
    logic [127:0] exp;
    mr = 1;
    mf = 0;
    for (int k = 0; k < 8; k++) begin
      if (mq[k].size() == 0) mr = 0;
      if (mq[k].size() == 64) mf = 1;
    end
    chk("valid", 128'(bus.valid), 128'(ev));
    if (bus.valid) begin
      if (sb.size() == 0) chk("sb_underflow", 128'(sb.size()), 128'd1);
      else begin
        exp = sb.pop_front();
        chk("row", bus.out_data, exp);
        last_out = exp;
      end
    end else chk("hold", bus.out_data, last_out);
    chk("ready", 128'(bus.ready), 128'(mr));
    chk("full", 128'(bus.full), 128'(mf));
    chk("ovf", 128'(bus.ovf), 128'(e_ovf));
    chk("unf", 128'(bus.unf), 128'(e_unf));
  endtask
  task automatic cyc(input logic [7:0] w, input logic [127:0] d, input logic r);
    int sz [8];
    bit mr, mp;
    logic [127:0] row;
    @(negedge clk);
    bus.wr = w;
    bus.in_data = d;
    bus.rd = r;
    mr = 1;
    for (int k = 0; k < 8; k++) begin
      sz[k] = mq[k].size();
      if (sz[k] == 0) mr = 0;
    end
    mp = r && mr;
    if (r && !mr) e_unf = 1;
    if (mp) begin
      for (int k = 0; k < 8; k++) row[k*16 +: 16] = mq[k].pop_front();
      sb.push_back(row);
    end
    for (int k = 0; k < 8; k++)
      if (w[k]) begin
        if (sz[k] < 64 || mp) mq[k].push_back(d[k*16 +: 16]);
        else e_ovf = 1;
      end
    @(posedge clk);
    #1;
    check_outputs(mp);
  endtask
  task automatic do_reset();
    bus.wr = '0;
    bus.rd = 1'b0;
    bus.in_data = '0;
    #2 reset = 1'b1;
    #1;
    chk("rst_ready", 128'(bus.ready), 128'd0);
    chk("rst_full", 128'(bus.full), 128'd0);
    chk("rst_valid", 128'(bus.valid), 128'd0);
    chk("rst_ovf", 128'(bus.ovf), 128'd0);
    chk("rst_unf", 128'(bus.unf), 128'd0);
    chk("rst_out", bus.out_data, 128'd0);
    for (int k = 0; k < 8; k++) mq[k].delete();
    sb.delete();
    last_out = '0;
    e_ovf = 0;
    e_unf = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask
  function automatic logic [127:0] splat(input logic [15:0] v);
    logic [127:0] r;
    for (int k = 0; k < 8; k++) r[k*16 +: 16] = v;
    return r;
  endfunction
  function automatic logic [127:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    logic [127:0] d;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      d = '0;
      d[k*16 +: 16] = 16'h0100 + 16'(k);
      cyc(8'(1 << k), d, 1'b1);
    end
    cyc(8'h00, '0, 1'b1);
    chk("skew_row", bus.out_data, 128'h0107_0106_0105_0104_0103_0102_0101_0100);
    cyc(8'h00, '0, 1'b0);
    cyc(8'h00, '0, 1'b0);
    do_reset();
    for (int i = 0; i < 64; i++) cyc(8'hFF, splat(16'(i)), 1'b0);
    d = '0;
    d[3*16 +: 16] = 16'hDEAD;
    cyc(8'h08, d, 1'b0);
    for (int i = 0; i < 64; i++) cyc(8'h00, '0, 1'b1);
    do_reset();
    for (int i = 0; i < 64; i++) cyc(8'hFF, splat(16'(i)), 1'b0);
    d = '0;
    d[3*16 +: 16] = 16'hBEEF;
    cyc(8'h08, d, 1'b1);
    cyc(8'hF7, splat(16'h0077), 1'b0);
    for (int i = 0; i < 64; i++) cyc(8'h00, '0, 1'b1);
    do_reset();
    cyc(8'hDF, splat(16'h0011), 1'b0);
    cyc(8'hDF, splat(16'h0022), 1'b0);
    cyc(8'h00, '0, 1'b1);
    cyc(8'h00, '0, 1'b0);
    cyc(8'h20, splat(16'h0055), 1'b0);
    cyc(8'h00, '0, 1'b1);
    cyc(8'h00, '0, 1'b0);
    do_reset();
    for (int i = 0; i < 10; i++) cyc(8'hFF, rnd(), 1'b0);
    for (int i = 0; i < 200; i++) cyc(8'hFF, rnd(), 1'b1);
    for (int i = 0; i < 10; i++) cyc(8'h00, '0, 1'b1);
    cyc(8'h00, '0, 1'b1);
    do_reset();
    for (int i = 0; i < 10; i++) cyc(8'hFF, rnd(), 1'b0);
    do_reset();
    cyc(8'hFF, splat(16'hA5A5), 1'b0);
    cyc(8'h00, '0, 1'b1);
    cyc(8'h00, '0, 1'b0);
    chk("sb_drained", 128'(sb.size()), 128'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ofifo_col.md
Name: ofifo_col

Overview:
- Output FIFO that receives the per-column accumulated/ReLU results produced by the SFP stage.
- Each column is an independent FIFO, written individually by the SFP per-column write enables.
- The downstream SRAM writeback reads the whole row at once, and only when every column holds data.
- Decouples skewed column arrival from the MAC array's last row from row-aligned writeback to output memory.

Parameters:
- col, 8, number of columns (one FIFO per column)
- psum_bw, 16, data width per column
- depth, 64, entries per column FIFO; power of two, at least 2

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- in  input  psum_bw*col  column k data in bits [(k+1)*psum_bw-1 : k*psum_bw]
- wr  input  col  per-column write enable
- rd  input  1  row read request
- out  output  psum_bw*col  registered row read data, same column packing as in
- o_valid  output  1  out updated with a new row this cycle (registered)
- o_ready  output  1  every column non-empty; a row read is possible
- o_full  output  1  at least one column full; upstream must stall
- o_ovf  output  1  sticky: a write was dropped on a full column
- o_unf  output  1  sticky: rd asserted while o_ready low

Behaviour:
- Reset (async): all read/write pointers 0, out = 0, o_valid = 0, o_ovf = 0, o_unf = 0. Result: o_ready = 0, o_full = 0.
- Reset mid-operation discards all stored data immediately; no partial row is emitted.
- Pointers are log2(depth)+1 bits.
  - empty[k] = (wptr == rptr)
  - full[k] = MSBs differ, lower bits equal
  - Pointers wrap naturally at 2*depth.
- Column write, evaluated per column k per cycle:
  - wr[k] && !full[k]: store in[k] at wptr[k], wptr[k]++.
  - wr[k] && full[k] && row pop this cycle: write accepted; occupancy unchanged.
  - wr[k] && full[k] && no row pop: write dropped, o_ovf set.
- Row pop occurs when rd && o_ready:
  - All col rptrs increment together.
  - out <= head entry of every column (registered, 1-cycle latency).
  - o_valid = 1 the following cycle.
- rd && !o_ready:
  - No pointer change, out holds, o_valid = 0 next cycle.
  - o_unf set.
- No pop: out holds its last value; o_valid = 0.
- o_ready = AND over k of !empty[k] (combinational from pointers).
- o_full = OR over k of full[k] (combinational).
- Same-cycle write and pop on an empty column cannot occur, because o_ready requires non-empty.
  - A write into an empty column becomes readable the next cycle (o_ready can rise one cycle after the last column's write).
- Back-to-back pops every cycle are supported: throughput is 1 row/cycle while o_ready holds.
- Data is passed through unchanged; no sign handling, no arithmetic.
- Sticky flags clear only on reset.

Decomposition:
- Shared package holds:
  - default col, psum_bw, depth constants
  - derived pointer-width constant (clog2(depth)+1)
- One sub-module, fifo_col: single-column synchronous FIFO.
  - Inputs: wr, din, pop.
  - Outputs: dout, empty, full, ovf pulse.
- ofifo_col instantiates col copies via generate and adds:
  - the row-level AND/OR reductions
  - the output register
  - the sticky flags

Test Plan:
- Fill all columns skewed: column k written at cycle k with value 0x0100+k, rd held high -> o_ready rises the cycle after column 7's write; one cycle after the pop, out = {0x0107,...,0x0100} with o_valid = 1 for exactly one cycle.
- Write 64 entries to every column, then one extra write on column 3 with no rd -> o_full = 1 after entry 64; extra write dropped, o_ovf = 1; subsequent 64 pops return values 0..63 in order.
- Column 3 full, wr[3] = 1 with value 0xBEEF on the same cycle as a pop -> write accepted, o_ovf stays 0, column 3 remains full; 0xBEEF appears on the 64th pop after that cycle.
- rd asserted while column 5 is empty -> no pointer movement, out unchanged, o_valid = 0, o_unf = 1 and stays 1.
- Pointer wrap: 200 rows streamed with concurrent write/pop, occupancy kept between 1 and 63 -> every row read matches its write order; o_full and o_ovf never assert.
- Reset asserted asynchronously with 10 rows stored -> o_ready, o_full, o_valid, o_ovf, o_unf all 0 immediately and out = 0; a fresh write then pop returns the new data.
